// File: rtl/bcd_pkg.sv
// Shared constants and elaboration-time helpers for the decimal counter family.
// Vectors are sized for the widest supported counter (8 digits, 32 bits).
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam int         MAX_DIG  = 8;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  function automatic logic [MAX_DIG*DIGIT_W-1:0] int_to_bcd(input int val);
    logic [MAX_DIG*DIGIT_W-1:0] r;
    int v;
    r = '0;
    v = val;
    for (int i = 0; i < MAX_DIG; i++) begin
      r[i*DIGIT_W +: DIGIT_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic is_bcd(input logic [MAX_DIG*DIGIT_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage: steps its digit up or down and flags carry/borrow on rollover.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               step_i,
  input  logic               up_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               carry_o
);

  always_comb begin
    digit_o = digit_i;
    carry_o = 1'b0;
    if (step_i) begin
      if (up_i) begin
        if (digit_i >= BCD_MAX) begin
          digit_o = '0;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == '0) begin
          digit_o = BCD_MAX;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with arbitrary modulus, clear, validated load and wrap strobe.
// A ripple chain of decade stages does the arithmetic; the modulus wrap overrides it.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MOD_VAL = 10**DIGITS
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      UP,
  input  logic                      CLR,
  input  logic                      LOAD,
  input  logic [DIGIT_W*DIGITS-1:0] LOAD_VAL,
  output logic [DIGIT_W*DIGITS-1:0] OUT,
  output logic                      WRAP,
  output logic                      LOAD_ERR
);

  localparam int W = DIGIT_W * DIGITS;
  localparam logic [MAX_DIG*DIGIT_W-1:0] TERM_FULL = int_to_bcd(MOD_VAL - 1);
  localparam logic [W-1:0]               TERM_BCD  = TERM_FULL[W-1:0];

  if (DIGITS < 1 || DIGITS > MAX_DIG) begin : g_bad_digits
    $error("bcd_counter_n: DIGITS must be 1..8");
  end
  if (MOD_VAL < 2 || MOD_VAL > 10**DIGITS) begin : g_bad_mod
    $error("bcd_counter_n: MOD_VAL must be 2..10**DIGITS");
  end

  logic [W-1:0] out_q, out_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic [W-1:0] ripple;
  logic [DIGITS:0] step;
  logic         load_ok;
  logic         unused_top_carry;

  assign step[0] = EN;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .step_i  (step[i]),
      .up_i    (UP),
      .digit_i (out_q[i*DIGIT_W +: DIGIT_W]),
      .digit_o (ripple[i*DIGIT_W +: DIGIT_W]),
      .carry_o (step[i+1])
    );
  end

  assign unused_top_carry = step[DIGITS];

  // With every nibble valid, BCD ordering matches decimal ordering.
  assign load_ok = is_bcd(32'(LOAD_VAL)) && (LOAD_VAL <= TERM_BCD);

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (CLR) begin
      out_d = '0;
    end else if (LOAD) begin
      if (load_ok) out_d = LOAD_VAL;
      else         err_d = 1'b1;
    end else if (EN) begin
      if (UP && out_q == TERM_BCD) begin
        out_d  = '0;
        wrap_d = 1'b1;
      end else if (!UP && out_q == '0) begin
        out_d  = TERM_BCD;
        wrap_d = 1'b1;
      end else begin
        out_d = ripple;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign OUT      = out_q;
  assign WRAP     = wrap_q;
  assign LOAD_ERR = err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Three counter configurations share one stimulus stream; an integer-valued model
// per configuration feeds expected outputs into queues drained by a monitor.
module tb_bcd_counter_n;

  localparam int NI = 3;
  localparam int MODS [NI] = '{100, 60, 250};
  localparam int DIGS [NI] = '{2, 2, 3};

  typedef struct {
    logic [11:0] out;
    logic        wrap;
    logic        err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0, UP = 1'b1, CLR = 1'b0, LOAD = 1'b0;
  logic [11:0] LOAD_VAL = '0;

  logic [7:0]  out0, out1;
  logic [11:0] out2;
  logic        wrap0, wrap1, wrap2, err0, err1, err2;

  int   checks = 0;
  int   failures = 0;
  int   mv [NI];
  exp_t q0[$], q1[$], q2[$];

  always #5 CLK = ~CLK;

  bcd_counter_n #(.DIGITS(2), .MOD_VAL(100)) u0 (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL[7:0]), .OUT(out0), .WRAP(wrap0), .LOAD_ERR(err0));
  bcd_counter_n #(.DIGITS(2), .MOD_VAL(60)) u1 (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL[7:0]), .OUT(out1), .WRAP(wrap1), .LOAD_ERR(err1));
  bcd_counter_n #(.DIGITS(3), .MOD_VAL(250)) u2 (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .OUT(out2), .WRAP(wrap2), .LOAD_ERR(err2));

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Reference behaviour on a plain integer count, evaluated at each rising edge.
  task automatic model_update();
    for (int k = 0; k < NI; k++) begin
      exp_t e;
      int   dec;
      int   nib;
      bit   ok;
      e.wrap = 1'b0;
      e.err  = 1'b0;
      if (!RST) begin
        mv[k] = 0;
      end else if (CLR) begin
        mv[k] = 0;
      end else if (LOAD) begin
        ok = 1'b1;
        dec = 0;
        for (int d = DIGS[k] - 1; d >= 0; d--) begin
          nib = int'(LOAD_VAL[d*4 +: 4]);
          if (nib > 9) ok = 1'b0;
          dec = dec * 10 + nib;
        end
        if (ok && dec < MODS[k]) mv[k] = dec;
        else e.err = 1'b1;
      end else if (EN) begin
        if (UP) begin
          if (mv[k] == MODS[k] - 1) begin mv[k] = 0; e.wrap = 1'b1; end
          else mv[k] = mv[k] + 1;
        end else begin
          if (mv[k] == 0) begin mv[k] = MODS[k] - 1; e.wrap = 1'b1; end
          else mv[k] = mv[k] - 1;
        end
      end
      e.out = to_bcd(mv[k]);
      push(k, e);
    end
  endtask

  task automatic compare(input int k, input logic [11:0] o, input logic w,
                         input logic er, input exp_t e);
    checks++;
    if (o !== e.out || w !== e.wrap || er !== e.err) begin
      failures++;
      $display("FAIL u%0d cycle_check t=%0t: got out=%h wrap=%b err=%b, want out=%h wrap=%b err=%b",
               k, $time, o, w, er, e.out, e.wrap, e.err);
    end
  endtask

  always @(negedge CLK) begin
    if (q0.size() > 0) compare(0, {4'h0, out0}, wrap0, err0, q0.pop_front());
    if (q1.size() > 0) compare(1, {4'h0, out1}, wrap1, err1, q1.pop_front());
    if (q2.size() > 0) compare(2, out2, wrap2, err2, q2.pop_front());
  end

  task automatic step(input logic en, input logic up, input logic clr,
                      input logic ld, input logic [11:0] v);
    EN = en; UP = up; CLR = clr; LOAD = ld; LOAD_VAL = v;
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic check_zero_now(input string name);
    checks++;
    if (out0 !== 8'h00 || out1 !== 8'h00 || out2 !== 12'h000 ||
        {wrap0, wrap1, wrap2, err0, err1, err2} !== 6'b0) begin
      failures++;
      $display("FAIL %s: got out=%h/%h/%h strobes=%b, want all zero", name,
               out0, out1, out2, {wrap0, wrap1, wrap2, err0, err1, err2});
    end
  endtask

  initial begin
    logic        up_dir;
    int          r;
    logic [11:0] v;

    for (int k = 0; k < NI; k++) mv[k] = 0;
    #1 check_zero_now("reset_async");
    @(negedge CLK);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    RST = 1'b1;

    // count to 37, then reset between edges
    repeat (37) step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    #2 RST = 1'b0;
    #1 check_zero_now("reset_mid_count");
    for (int k = 0; k < NI; k++) mv[k] = 0;
    @(negedge CLK);
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    RST = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);

    // full up wrap from 00
    step(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    repeat (102) step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);

    // down wrap from 01
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h001);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);

    // modulus boundary around 58/59
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h058);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h249);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);

    // load validation
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h057);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h05A);
    step(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h075);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h250);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'hA01);

    // simultaneous controls
    step(1'b1, 1'b1, 1'b1, 1'b1, 12'h042);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h099);
    step(1'b1, 1'b1, 1'b0, 1'b1, 12'h023);
    step(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);

    // randomized traffic
    up_dir = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) up_dir = ~up_dir;
      if ($urandom_range(0, 1) == 1) v = to_bcd($urandom_range(0, 249));
      else                           v = 12'($urandom);
      step($urandom_range(0, 3) != 0, up_dir, r < 3, (r >= 3 && r < 15), v);
    end

    repeat (3) @(negedge CLK);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q0.size() + q1.size() + q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
